// File: rtl/drone_pkg.sv
// drone_pkg: shared definitions for the drone control blocks.
//   NUM_CH     : number of PPM channel slots (roll, pitch, throttle, yaw)
//   SYNC_SLOT  : value of the slot index while the frame is in its sync gap
//   ppm_state_t: PPM encoder frame sequencer states
//   PPM_*      : default PPM timing (microseconds, 27 MHz labkit clock)
package drone_pkg;

  localparam int NUM_CH = 4;
  localparam logic [2:0] SYNC_SLOT = 3'd4;

  typedef enum logic [2:0] {
    LATCH,
    SEP,
    HIGH,
    SYNC_SEP,
    SYNC_GAP
  } ppm_state_t;

  localparam int PPM_TICK_DIV  = 27;
  localparam int PPM_FRAME_US  = 22500;
  localparam int PPM_SEP_US    = 300;
  localparam int PPM_MIN_US    = 1000;
  localparam int PPM_YAW_US    = 1500;
  // Slot width used for roll/pitch while disarmed (stick centred).
  localparam int PPM_CENTER_US = 1500;

endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: free-running prescaler producing a one-cycle tick per
// microsecond.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-low reset (clears the prescaler)
//   tick  : high for one cycle when the prescaler wraps (every TICK_DIV cycles)
module us_tick_gen
  import drone_pkg::*;
#(
  parameter int TICK_DIV = PPM_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/ppm_encoder.sv
// ppm_encoder: converts gest_rec commands into an RC PPM pulse train for the
// transmitter trainer port.
// Ports:
//   clock      : system clock
//   reset      : asynchronous, active-low reset
//   hover      : throttle command (0..255)
//   roll       : roll command (0..255)
//   pitch      : pitch command (0..255)
//   on         : armed flag; when low, throttle is minimum and roll/pitch centred
//   ppm        : PPM output, idle high, low separator pulses
//   frame_sync : one-cycle pulse as a new frame's slot widths take effect
//   chan       : current slot index, 0..3 channels, 4 = sync gap
// Build option:
//   PPM_INVERT_EN : when defined, ppm is inverted (idle/reset low, separators high)
// Assumes TICK_DIV >= 2.
module ppm_encoder
  import drone_pkg::*;
#(
  parameter int TICK_DIV = PPM_TICK_DIV,
  parameter int FRAME_US = PPM_FRAME_US,
  parameter int SEP_US   = PPM_SEP_US,
  parameter int MIN_US   = PPM_MIN_US,
  parameter int YAW_US   = PPM_YAW_US
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] hover,
  input  logic [7:0] roll,
  input  logic [7:0] pitch,
  input  logic       on,
  output logic       ppm,
  output logic       frame_sync,
  output logic [2:0] chan
);

  localparam logic [10:0] SEP_LAST   = 11'(SEP_US - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_US - 1);
  localparam logic [10:0] MIN_W      = 11'(MIN_US);
  localparam logic [10:0] YAW_W      = 11'(YAW_US);
  localparam logic [10:0] CENTER_W   = 11'(PPM_CENTER_US);
  localparam logic [2:0]  LAST_CH    = 3'(NUM_CH - 1);

`ifdef PPM_INVERT_EN
  localparam logic IDLE_LVL = 1'b0;
`else
  localparam logic IDLE_LVL = 1'b1;
`endif
  localparam logic SEP_LVL = ~IDLE_LVL;

  // w = MIN_US + (v*1000)/256, truncated; v=255 gives 1996.
  function automatic logic [10:0] slot_width(input logic [7:0] v);
    logic [17:0] prod;
    prod = 18'(v) * 18'd1000;
    return MIN_W + {1'b0, prod[17:8]};
  endfunction

  logic        tick;
  logic        step;
  ppm_state_t  state, state_n;
  logic [2:0]  chan_n;
  logic [10:0] slot_us, slot_n;
  logic [15:0] elapsed_us, elapsed_n;
  logic        latch;
  logic        ppm_n;
  logic [10:0] cur_w;
  logic [10:0] width [NUM_CH];

  us_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // Slot timing runs on the tick delayed by one cycle. The sync gap ends on
  // the raw tick, so the single LATCH cycle sits just before a timing step
  // and every slot, and the frame, is an exact multiple of TICK_DIV cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step       <= 1'b0;
      state      <= LATCH;
      chan       <= SYNC_SLOT;
      slot_us    <= '0;
      elapsed_us <= '0;
      ppm        <= IDLE_LVL;
      frame_sync <= 1'b0;
    end else begin
      step       <= tick;
      state      <= state_n;
      chan       <= chan_n;
      slot_us    <= slot_n;
      elapsed_us <= elapsed_n;
      ppm        <= ppm_n;
      frame_sync <= latch;
    end
  end

  // Frame snapshot of the four slot widths; inputs are ignored mid-frame.
  always_ff @(posedge clock) begin
    if (latch) begin
      width[0] <= on ? slot_width(roll)  : CENTER_W;
      width[1] <= on ? slot_width(pitch) : CENTER_W;
      width[2] <= on ? slot_width(hover) : MIN_W;
      width[3] <= YAW_W;
    end
  end

  always_comb begin
    state_n   = state;
    chan_n    = chan;
    slot_n    = slot_us;
    elapsed_n = step ? elapsed_us + 16'd1 : elapsed_us;
    latch     = 1'b0;
    cur_w     = width[chan[1:0]];

    case (state)
      LATCH: begin
        latch     = 1'b1;
        chan_n    = 3'd0;
        slot_n    = '0;
        elapsed_n = '0;
        state_n   = SEP;
      end
      SEP: begin
        if (step) begin
          slot_n = slot_us + 11'd1;
          if (slot_us == SEP_LAST) state_n = HIGH;
        end
      end
      // slot_us keeps counting from the start of SEP, so separator plus
      // high phase together equal the slot width.
      HIGH: begin
        if (step) begin
          if (slot_us == cur_w - 11'd1) begin
            slot_n = '0;
            if (chan == LAST_CH) begin
              chan_n  = SYNC_SLOT;
              state_n = SYNC_SEP;
            end else begin
              chan_n  = chan + 3'd1;
              state_n = SEP;
            end
          end else begin
            slot_n = slot_us + 11'd1;
          end
        end
      end
      SYNC_SEP: begin
        if (step) begin
          slot_n = slot_us + 11'd1;
          if (slot_us == SEP_LAST) state_n = SYNC_GAP;
        end
      end
      SYNC_GAP: begin
        if (tick && elapsed_us == FRAME_LAST) state_n = LATCH;
      end
      default: state_n = LATCH;
    endcase

    ppm_n = (state_n == SEP || state_n == SYNC_SEP) ? SEP_LVL : IDLE_LVL;
  end

endmodule

// File: tb/tb_ppm_encoder.sv
// tb_ppm_encoder: scoreboard bench for ppm_encoder. Expected frame slot
// widths are queued when the commands are driven and compared against the
// measured ppm edge timing when each frame completes.
module tb_ppm_encoder;
  import drone_pkg::*;

  localparam int TD  = 2;
  localparam int FUS = 8000;
  localparam int SUS = 300;

`ifdef PPM_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  localparam logic IDLE = INV ? 1'b0 : 1'b1;
  localparam logic SEPL = INV ? 1'b1 : 1'b0;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] hover = '0;
  logic [7:0] roll  = '0;
  logic [7:0] pitch = '0;
  logic       on    = 1'b0;
  logic       ppm;
  logic       frame_sync;
  logic [2:0] chan;

  ppm_encoder #(
    .TICK_DIV(TD),
    .FRAME_US(FUS),
    .SEP_US  (SUS),
    .MIN_US  (1000),
    .YAW_US  (1500)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .hover     (hover),
    .roll      (roll),
    .pitch     (pitch),
    .on        (on),
    .ppm       (ppm),
    .frame_sync(frame_sync),
    .chan      (chan)
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int w0;
    int w1;
    int w2;
    int w3;
  } frame_exp_t;

  frame_exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int frames_done = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cmd_us(input int v);
    return 1000 + (v * 1000) / 256;
  endfunction

  task automatic push_exp(input int a, input int b, input int c, input int d);
    frame_exp_t e;
    e.w0 = a; e.w1 = b; e.w2 = c; e.w3 = d;
    sb.push_back(e);
  endtask

  // Monitor: records falling/rising edge times of the normalised ppm level
  // within each frame and scores the frame at the next frame_sync.
  longint ft[5];
  longint rt[5];
  longint fs_t;
  int     nf, nr;
  bit     in_frame;

  task automatic close_frame();
    frame_exp_t e;
    int w[4];
    chk($sformatf("f%0d_falls", frames_done), nf, 5);
    chk($sformatf("f%0d_rises", frames_done), nr, 5);
    chk($sformatf("f%0d_sb_has_entry", frames_done), sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      w[0] = e.w0; w[1] = e.w1; w[2] = e.w2; w[3] = e.w3;
      for (int i = 0; i < 4; i++)
        chk($sformatf("f%0d_slot%0d", frames_done, i), ft[i+1] - ft[i], longint'(w[i] * TD));
      for (int i = 0; i < 5; i++)
        chk($sformatf("f%0d_low%0d", frames_done, i), rt[i] - ft[i], longint'(SUS * TD));
      chk($sformatf("f%0d_period", frames_done), cyc - fs_t, longint'(FUS * TD));
    end
    frames_done++;
  endtask

  initial begin
    logic lvl;
    logic prev_lvl;
    logic prev_fs;
    prev_lvl = 1'b1;
    prev_fs  = 1'b0;
    in_frame = 1'b0;
    nf = 0;
    nr = 0;
    forever begin
      @(negedge clock);
      lvl = ppm ^ INV;
      if (!reset) begin
        in_frame = 1'b0;
        nf = 0;
        nr = 0;
        prev_lvl = 1'b1;
        prev_fs  = 1'b0;
      end else begin
        if (prev_fs) chk("fs_one_cycle", frame_sync, 0);
        if (frame_sync) begin
          if (in_frame) close_frame();
          in_frame = 1'b1;
          fs_t = cyc;
          nf = 0;
          nr = 0;
        end
        if (in_frame && prev_lvl && !lvl) begin
          if (nf < 5) begin
            chk($sformatf("chan_at_fall%0d", nf), chan, (nf < 4) ? nf : 4);
            ft[nf] = cyc;
          end
          nf++;
        end
        if (in_frame && !prev_lvl && lvl) begin
          if (nr < 5) rt[nr] = cyc;
          nr++;
        end
        prev_lvl = lvl;
        prev_fs  = frame_sync;
      end
    end
  end

  task automatic wait_slot(input int c, input logic want_lvl, input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (chan == 3'(c) && (ppm ^ INV) == want_lvl) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_frames(input int n, input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (frames_done >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    // Frame A: armed, roll=0 pitch=128 hover=255.
    reset = 1'b0;
    on    = 1'b1;
    roll  = 8'd0;
    pitch = 8'd128;
    hover = 8'd255;
    push_exp(cmd_us(0), cmd_us(128), cmd_us(255), 1500);

    repeat (3) begin
      @(negedge clock);
      chk("rst_ppm", ppm, IDLE);
      chk("rst_chan", chan, 4);
      chk("rst_fs", frame_sync, 0);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("fs_after_release", frame_sync, 1);
    chk("chan_after_release", chan, 0);
    chk("ppm_first_sep", ppm, SEPL);

    // Mid-slot-2 roll change must only show up in frame B.
    wait_slot(2, 1'b1, "reach_slot2_high", 10000);
    roll = 8'd255;
    push_exp(cmd_us(255), cmd_us(128), cmd_us(255), 1500);

    wait_frames(2, "frames_ab_done", 3 * FUS * TD);

    // Frame C is aborted by reset during its ch1 high phase; the fresh frame
    // after release uses the disarmed commands.
    wait_slot(1, 1'b1, "reach_c_slot1_high", 10000);
    on    = 1'b0;
    hover = 8'd255;
    roll  = 8'd0;
    pitch = 8'd255;
    push_exp(1500, 1500, 1000, 1500);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_ppm", ppm, IDLE);
    chk("async_rst_chan", chan, 4);
    chk("async_rst_fs", frame_sync, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("fs_fresh_frame", frame_sync, 1);
    chan_chk: chk("chan_fresh_frame", chan, 0);

    wait_frames(3, "frame_e_done", 3 * FUS * TD);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ppm_encoder.md
Name: ppm_encoder

Overview:
- Downstream consumer of gest_rec.
- Converts its 8-bit hover, roll and pitch commands plus the on flag into a standard RC PPM pulse train.
- The PPM output drives the trainer port of the drone's handheld transmitter.
- Channel values are snapshotted once per frame; the encoder then free-runs with a fixed frame period derived from a microsecond tick.

Parameters:
- TICK_DIV, 27: clock cycles per 1 us tick (27 MHz labkit clock).
- FRAME_US, 22500: total frame length in us.
- SEP_US, 300: low separator pulse length in us.
- MIN_US, 1000: channel slot length for command value 0.
- YAW_US, 1500: fixed slot length for channel 4 (yaw, not gesture-controlled).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- hover  in  8  throttle command from gest_rec
- roll  in  8  roll command from gest_rec
- pitch  in  8  pitch command from gest_rec
- on  in  1  gest_rec armed flag
- ppm  out  1  PPM pulse train; idle level high
- frame_sync  out  1  one-cycle pulse on the cycle the new frame's values are latched
- chan  out  3  current slot index: 0..3 = channels, 4 = sync gap

Behaviour:
- Reset (reset=0, async): ppm=1, frame_sync=0, chan=4, prescaler and us counters cleared, state=LATCH. A reset mid-frame aborts the frame immediately; no partial pulse is completed.
- us tick: prescaler counts 0..TICK_DIV-1. tick asserts for one cycle when the count wraps. All slot timing advances only on tick.
- Slot width: w = MIN_US + ((v*1000) >> 8).
  - v=0 -> 1000; v=128 -> 1500; v=255 -> 1996.
  - 18-bit intermediate product; 11-bit result.
- Channel order: ch0 = roll, ch1 = pitch, ch2 = hover (throttle), ch3 = YAW_US.
- If on=0 at latch: throttle slot = 1000, roll and pitch slots = 1500 (centred). If on=1: computed widths.
- States:
  - LATCH (1 cycle): capture the four widths into slot registers; frame_sync=1; clear elapsed_us; chan=0 -> SEP.
  - SEP: ppm=0 for SEP_US ticks -> HIGH.
  - HIGH: ppm=1 until slot_us reaches w[chan]; slot_us counts from the start of SEP, so the slot total equals w. Then: if chan<3, chan++ -> SEP; else chan=4 -> SYNC_SEP.
  - SYNC_SEP: ppm=0 for SEP_US -> SYNC_GAP.
  - SYNC_GAP: ppm=1 until elapsed_us == FRAME_US-1 -> LATCH.
- Frame period is exactly FRAME_US*TICK_DIV cycles, independent of the command values.
- Worst-case sync gap = 22500 - 3*1996 - 1500 - 300 = 14712 us, which is always positive.
- Input changes mid-frame have no effect until the next LATCH; there is no tearing.
- elapsed_us is 16-bit and never wraps within a frame.

Optional Feature:
- PPM_INVERT_EN defined: ppm output inverted. Idle and reset level become 0; separators are high. Used for transmitters with inverting trainer inputs.
- Not defined: polarity exactly as described above.

Decomposition:
- Shared package drone_pkg:
  - NUM_CH=4.
  - Slot-index constant SYNC_SLOT=4.
  - State enum {LATCH, SEP, HIGH, SYNC_SEP, SYNC_GAP}.
  - PPM timing defaults.
- One sub-module: us_tick_gen (prescaler; ports clock, reset, tick).
- Width computation and FSM stay in ppm_encoder.

Test Plan:
- TICK_DIV=2, reset low 3 cycles then high -> ppm=1 and chan=4 during reset; frame_sync pulses 1 cycle after release; first ppm falling edge follows.
- on=1, roll=0, pitch=128, hover=255 -> consecutive falling-edge spacings = 1000, 1500, 1996, 1500 us; each low phase = 300 us; frame period = 22500 us.
- on=0 with hover=255, roll=0, pitch=255 -> slots 1500, 1500, 1000, 1500 us.
- Change roll from 0 to 255 mid-slot-2 -> current frame keeps 1000 us for ch0; next frame shows 1996 us.
- Assert reset during a HIGH slot -> ppm=1 in the same cycle (async); after release a full fresh frame begins with frame_sync.
- Build with PPM_INVERT_EN defined, repeat scenario 2 -> ppm is the bitwise complement at every sample; reset level 0.
